line_mem_adapter: RTL and testbench
===================================

Name: line_mem_adapter

Overview:
- Memory-side neighbour of the data cache.
- Accepts 128-bit line read and write requests from the cache refill/writeback port (mem_r/mem_w/mem_addr/mem_data_out → mem_data/mem_ready).
- Serialises each request into four 32-bit word beats on a req/ack main-memory bus.
- Assembles read beats into a line buffer, and signals completion or timeout back to the cache.

Parameters:
- TIMEOUT, 255: maximum cycles one beat waits for ram_ack before abort. 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- mem_r  in  1  line read request (refill); held until mem_ready
- mem_w  in  1  line write request (writeback); held until mem_ready
- mem_addr  in  32  line address; bits [3:0] ignored
- mem_data_out  in  128  line to write; word k = bits [32k+31:32k]
- mem_data  out  128  assembled read line, same word order
- mem_ready  out  1  one-cycle completion pulse
- mem_err  out  1  one-cycle pulse with mem_ready when a beat timed out
- ram_req  out  1  beat request
- ram_we  out  1  1 = write beat, 0 = read beat
- ram_addr  out  32  word address of current beat
- ram_wdata  out  32  write word of current beat
- ram_rdata  in  32  read word; sampled on the ack cycle
- ram_ack  in  1  beat completes at the clock edge where ram_req and ram_ack are both high

Behaviour:
- Reset (asynchronous, immediate, legal mid-transfer):
  - State returns to IDLE. Beat counter, timeout counter, line buffer, latched address and latched write line all clear to 0.
  - All outputs go to 0. ram_req drops without waiting for ack, and a pending beat is abandoned.
- States:
  - IDLE → WR when mem_w=1 (mem_w has priority; mem_r in the same cycle is ignored until re-requested).
  - IDLE → RD when mem_r=1 and mem_w=0.
  - WR/RD → DONE after the beat-3 ack, or on timeout.
  - DONE → IDLE unconditionally after one cycle.
- Acceptance (IDLE edge):
  - Latch base = {mem_addr[31:4], 4'b0}.
  - For WR, latch mem_data_out; later changes on the cache-side inputs have no effect.
  - Beat counter = 0, timeout counter = 0.
- WR/RD outputs:
  - ram_req=1; ram_we=1 in WR, 0 in RD.
  - ram_addr = {base[31:4], beat[1:0], 2'b00}.
  - ram_wdata = latched word[beat] in WR, 0 in RD.
  - ram_req, ram_we, ram_addr and ram_wdata are decoded from registered state only; no combinational path from ram_ack.
- Beat completion (ram_ack=1 at edge):
  - RD: line buffer word[beat] ← ram_rdata.
  - beat ← beat+1, timeout counter ← 0.
  - The next beat follows with no bubble (ram_req stays high).
  - ram_ack while ram_req=0 is ignored.
- Timeout:
  - The timeout counter increments each WR/RD cycle without ack.
  - When it equals TIMEOUT (TIMEOUT≠0), go to DONE with the error flag set.
  - Unreceived buffer words keep their prior values.
- DONE:
  - mem_ready=1 for exactly one cycle; mem_err=1 in the same cycle if aborted, else 0.
  - ram_req=0.
- mem_data:
  - Always drives the line buffer.
  - Stable from the DONE cycle until the next RD acceptance.
  - WR transactions never modify it.
- Latency with ram_ack tied high: request seen in IDLE at cycle N, beats at N+1..N+4, mem_ready at N+5.
  - Each wait cycle on a beat adds one cycle.
- Requester rule: mem_r/mem_w must drop or change in the cycle after mem_ready. Otherwise it is taken as a new request, and the adapter accepts it in that cycle.
- Back-to-back transactions: a dirty-miss writeback followed by refill costs 1 IDLE cycle between them.

Test Plan:
- Zero-wait read:
  - Stimulus: mem_r, mem_addr=0x0000_1234, ram_ack=1, ram_rdata=addr^0xA5A5_0000.
  - Required: ram_addr 0x1230, 0x1234, 0x1238, 0x123C; mem_ready at N+5; mem_data={0xA5A5_123C, 0xA5A5_1238, 0xA5A5_1234, 0xA5A5_1230}; mem_err=0.
- Write with waits:
  - Stimulus: mem_w, addr=0x8000_0040, line=0x44444444_33333333_22222222_11111111; ack after 2 wait cycles per beat.
  - Required: ram_we=1, ram_wdata 0x11111111 → 0x44444444 at 0x8000_0040..4C; mem_ready at N+13; mem_data unchanged.
- Dirty miss:
  - Stimulus: write of line 0x100 completes, then the requester switches to mem_r at 0x200.
  - Required: one IDLE cycle between the two transactions, then a correct read of 0x200..0x20C.
- Simultaneous request:
  - Stimulus: mem_r=mem_w=1.
  - Required: WR performed (ram_we=1 on all beats); mem_r serviced only when requested again after mem_ready.
- Timeout:
  - Stimulus: TIMEOUT=4; read with ack for beats 0–1 only.
  - Required: ram_req drops; mem_ready=mem_err=1 one cycle; words 0–1 updated, words 2–3 keep prior values.
- Reset mid-transfer:
  - Stimulus: assert rst during beat 2 of a read, asynchronously between edges.
  - Required: ram_req, mem_data, mem_ready and mem_err go to 0 immediately, state IDLE; a subsequent read behaves per scenario 1.

Source files
------------

// File: rtl/line_mem_adapter.sv
// Cache-line to word-beat adapter: splits 128-bit line reads/writes into four
// 32-bit req/ack beats and reassembles read beats into a line buffer.
module line_mem_adapter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_r,
    input  logic         mem_w,
    input  logic [31:0]  mem_addr,
    input  logic [127:0] mem_data_out,
    output logic [127:0] mem_data,
    output logic         mem_ready,
    output logic         mem_err,
    output logic         ram_req,
    output logic         ram_we,
    output logic [31:0]  ram_addr,
    output logic [31:0]  ram_wdata,
    input  logic [31:0]  ram_rdata,
    input  logic         ram_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam bit          TMO_EN   = (TIMEOUT != 0);
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

    state_t       state_q;
    logic [1:0]   beat_q;
    logic [31:0]  tmo_q;
    logic [127:0] buf_q;
    logic [127:0] wline_q;
    logic [27:0]  base_q;
    logic         req_q;
    logic         we_q;
    logic         ready_q;
    logic         err_q;

    // The low nibble of the line address selects nothing in a line transfer.
    logic unused_addr_bits;
    assign unused_addr_bits = ^mem_addr[3:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= 2'd0;
            tmo_q   <= 32'd0;
            buf_q   <= 128'd0;
            wline_q <= 128'd0;
            base_q  <= 28'd0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mem_w || mem_r) begin
                        state_q <= mem_w ? WR : RD;
                        req_q   <= 1'b1;
                        we_q    <= mem_w;
                        base_q  <= mem_addr[31:4];
                        beat_q  <= 2'd0;
                        tmo_q   <= 32'd0;
                        if (mem_w) begin
                            wline_q <= mem_data_out;
                        end
                    end
                end
                WR, RD: begin
                    if (ram_ack) begin
                        if (state_q == RD) begin
                            buf_q[{beat_q, 5'b0} +: 32] <= ram_rdata;
                        end
                        beat_q <= beat_q + 2'd1;
                        tmo_q  <= 32'd0;
                        if (beat_q == 2'd3) begin
                            state_q <= DONE;
                            req_q   <= 1'b0;
                            we_q    <= 1'b0;
                            ready_q <= 1'b1;
                        end
                    end else begin
                        tmo_q <= tmo_q + 32'd1;
                        // Abort once this beat has waited TIMEOUT cycles.
                        if (TMO_EN && tmo_q == TMO_LAST) begin
                            state_q <= DONE;
                            req_q   <= 1'b0;
                            we_q    <= 1'b0;
                            ready_q <= 1'b1;
                            err_q   <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ram_req   = req_q;
    assign ram_we    = we_q;
    assign ram_addr  = {base_q, beat_q, 2'b00};
    assign ram_wdata = we_q ? wline_q[{beat_q, 5'b0} +: 32] : 32'd0;
    assign mem_data  = buf_q;
    assign mem_ready = ready_q;
    assign mem_err   = err_q;

endmodule

// File: tb/tb_line_mem_adapter.sv
// Randomized bench for line_mem_adapter: a per-cycle transaction timeline model
// drives the RAM side and one compare process checks every cycle against it.
module tb_line_mem_adapter;

    localparam int TMO = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         mem_r, mem_w;
    logic [31:0]  mem_addr;
    logic [127:0] mem_data_out;
    logic [127:0] mem_data;
    logic         mem_ready, mem_err;
    logic         ram_req, ram_we;
    logic [31:0]  ram_addr, ram_wdata, ram_rdata;
    logic         ram_ack;

    line_mem_adapter #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .mem_r(mem_r), .mem_w(mem_w), .mem_addr(mem_addr), .mem_data_out(mem_data_out),
        .mem_data(mem_data), .mem_ready(mem_ready), .mem_err(mem_err),
        .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .ram_ack(ram_ack)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model state: line buffer contents, read-data key, per-beat wait plan.
    logic [31:0] mbuf [4];
    logic [31:0] key;
    int          waits [4];

    logic         exp_valid = 1'b0;
    logic         exp_req, exp_we, exp_ready, exp_err;
    logic [31:0]  exp_addr, exp_wdata;
    logic [127:0] exp_line;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [127:0] model_line();
        return {mbuf[3], mbuf[2], mbuf[1], mbuf[0]};
    endfunction

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        return a ^ key;
    endfunction

    task automatic set_exp(input logic rq, input logic we, input logic [31:0] a,
                           input logic [31:0] wd, input logic rdy, input logic er);
        exp_valid = 1'b1;
        exp_req   = rq;
        exp_we    = we;
        exp_addr  = a;
        exp_wdata = wd;
        exp_ready = rdy;
        exp_err   = er;
        exp_line  = model_line();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_valid) begin
            chk("ram_req", {127'd0, ram_req}, {127'd0, exp_req});
            chk("mem_ready", {127'd0, mem_ready}, {127'd0, exp_ready});
            chk("mem_err", {127'd0, mem_err}, {127'd0, exp_err});
            chk("mem_data", mem_data, exp_line);
            if (exp_req) begin
                chk("ram_we", {127'd0, ram_we}, {127'd0, exp_we});
                chk("ram_addr", {96'd0, ram_addr}, {96'd0, exp_addr});
                chk("ram_wdata", {96'd0, ram_wdata}, {96'd0, exp_wdata});
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            mem_r = 1'b0;
            mem_w = 1'b0;
            mem_addr = $urandom;
            ram_ack = 1'($urandom);
            ram_rdata = $urandom;
            set_exp(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
            step();
        end
    endtask

    // One transaction from its IDLE acceptance cycle through DONE. Returns the
    // cycle index of mem_ready relative to acceptance (-1 if reset cut it off).
    task automatic txn(input logic w_op, input logic r_op, input logic [31:0] addr,
                       input logic [127:0] line, input int rst_beat, output int done_at);
        logic [31:0] base;
        logic        is_wr;
        logic        aborted;
        int          cyc;
        base    = {addr[31:4], 4'b0};
        is_wr   = w_op;
        aborted = 1'b0;
        cyc     = 0;
        done_at = -1;
        mem_w = w_op;
        mem_r = r_op;
        mem_addr = addr;
        mem_data_out = line;
        ram_ack = 1'($urandom);
        ram_rdata = $urandom;
        set_exp(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        step();
        for (int k = 0; k < 4 && !aborted; k++) begin
            logic [31:0] wa;
            logic [31:0] wd;
            wa = base + 32'(4 * k);
            wd = is_wr ? line[32*k +: 32] : 32'd0;
            if (k == rst_beat) begin
                exp_valid = 1'b0;
                ram_ack = 1'b0;
                #2;
                rst = 1'b1;
                #1;
                for (int j = 0; j < 4; j++) mbuf[j] = 32'd0;
                chk("rst_ram_req", {127'd0, ram_req}, 128'd0);
                chk("rst_mem_data", mem_data, model_line());
                chk("rst_mem_ready", {127'd0, mem_ready}, 128'd0);
                chk("rst_mem_err", {127'd0, mem_err}, 128'd0);
                mem_r = 1'b0;
                mem_w = 1'b0;
                #3;
                rst = 1'b0;
                step();
                return;
            end
            for (int c = 0; c < waits[k] && c < TMO; c++) begin
                ram_ack = 1'b0;
                ram_rdata = $urandom;
                mem_addr = $urandom;
                mem_data_out = {$urandom, $urandom, $urandom, $urandom};
                set_exp(1'b1, is_wr, wa, wd, 1'b0, 1'b0);
                step();
                cyc++;
            end
            if (waits[k] >= TMO) begin
                aborted = 1'b1;
            end else begin
                ram_ack = 1'b1;
                ram_rdata = rd_word(wa);
                set_exp(1'b1, is_wr, wa, wd, 1'b0, 1'b0);
                step();
                cyc++;
                if (!is_wr) mbuf[k] = rd_word(wa);
            end
        end
        ram_ack = 1'($urandom);
        ram_rdata = $urandom;
        set_exp(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, aborted);
        done_at = cyc + 1;
        step();
    endtask

    task automatic set_waits(input int a, input int b, input int c, input int d);
        waits[0] = a; waits[1] = b; waits[2] = c; waits[3] = d;
    endtask

    initial begin
        int lat;
        logic [127:0] prev;
        rst = 1'b1;
        mem_r = 1'b0; mem_w = 1'b0; mem_addr = 32'd0; mem_data_out = 128'd0;
        ram_ack = 1'b0; ram_rdata = 32'd0;
        for (int j = 0; j < 4; j++) mbuf[j] = 32'd0;
        #2;
        chk("reset_ram_req", {127'd0, ram_req}, 128'd0);
        chk("reset_mem_ready", {127'd0, mem_ready}, 128'd0);
        chk("reset_mem_data", mem_data, 128'd0);
        #21;
        rst = 1'b0;
        step();
        idle(2);

        // Zero-wait read
        key = 32'hA5A5_0000;
        set_waits(0, 0, 0, 0);
        txn(1'b0, 1'b1, 32'h0000_1234, 128'd0, -1, lat);
        chk("s1_latency", 128'(lat), 128'd5);
        chk("s1_model", model_line(), 128'hA5A5123C_A5A51238_A5A51234_A5A51230);
        idle(1);

        // Write with two wait cycles per beat; mem_data must not move
        set_waits(2, 2, 2, 2);
        txn(1'b1, 1'b0, 32'h8000_0040, 128'h44444444_33333333_22222222_11111111, -1, lat);
        chk("s2_latency", 128'(lat), 128'd13);
        chk("s2_mem_data", mem_data, 128'hA5A5123C_A5A51238_A5A51234_A5A51230);
        idle(2);

        // Dirty miss: writeback then immediate refill
        key = 32'h5A5A_0F0F;
        set_waits(0, 1, 0, 2);
        txn(1'b1, 1'b0, 32'h0000_0100, {$urandom, $urandom, $urandom, $urandom}, -1, lat);
        set_waits(1, 0, 0, 0);
        txn(1'b0, 1'b1, 32'h0000_0200, 128'd0, -1, lat);
        idle(1);

        // Simultaneous request: write wins, read only after re-request
        set_waits(0, 0, 1, 0);
        txn(1'b1, 1'b1, 32'h0000_0A00, {$urandom, $urandom, $urandom, $urandom}, -1, lat);
        idle(2);
        txn(1'b0, 1'b1, 32'h0000_0A00, 128'd0, -1, lat);
        idle(1);

        // Timeout on beat 2
        prev = model_line();
        key = 32'h1357_9BDF;
        set_waits(0, 0, 9, 0);
        txn(1'b0, 1'b1, 32'h0000_0300, 128'd0, -1, lat);
        chk("s5_model", model_line(),
            {prev[127:64], 32'h0000_0304 ^ 32'h1357_9BDF, 32'h0000_0300 ^ 32'h1357_9BDF});
        idle(2);

        // Reset mid-transfer during beat 2, then a clean zero-wait read
        set_waits(0, 0, 0, 0);
        txn(1'b0, 1'b1, 32'h0000_0700, 128'd0, 2, lat);
        idle(1);
        key = 32'hA5A5_0000;
        txn(1'b0, 1'b1, 32'h0000_1234, 128'd0, -1, lat);
        chk("s6_model", model_line(), 128'hA5A5123C_A5A51238_A5A51234_A5A51230);

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            logic wo, ro;
            key = $urandom;
            for (int k = 0; k < 4; k++)
                waits[k] = ($urandom_range(0, 15) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3);
            wo = 1'($urandom);
            ro = ~wo | 1'($urandom);
            txn(wo, ro, $urandom, {$urandom, $urandom, $urandom, $urandom}, -1, lat);
            idle($urandom_range(0, 2));
        end

        exp_valid = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
